read_module: RTL and testbench

READ_MODULE -- requirements
Module: read_module

---
 rtl/read_module.sv | 102 ++++++++++
 tb/tb_read_module.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/read_module.sv
// FIFO read-side consumer: pops one word per transaction, tracks count and parity/order errors.
// Optional sequence-order checking is enabled by defining READ_SEQ_CHECK_EN.
module read_module #(
   parameter int DW  = 16,
   parameter int ECW = 8
) (
   input  logic           rclk,
   input  logic           rrst,
   input  logic           rempty,
   input  logic [DW-1:0]  rdata,
   output logic           rinc,
   output logic [DW-1:0]  rword,
   output logic           rvalid,
   output logic [15:0]    word_cnt,
   output logic           parity_err,
   output logic           seq_err,
   output logic [ECW-1:0] err_cnt,
   output logic [1:0]     state
);

   // Handshake: the FIFO is show-ahead, so rdata is valid whenever rempty=0.
   // rinc is a one-cycle pop strobe in POP, and rdata is captured into rword on
   // that same edge. rvalid pulses for one cycle in CHECK when rword is counted.
   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_POP   = 2'd2;
   localparam logic [1:0] S_CHECK = 2'd3;

   logic [1:0]     state_next;
   logic           par_hit;
   logic           seq_hit;
   logic [ECW:0]   err_sum;
   logic [ECW-1:0] err_next;

   always_comb begin
      state_next = state;
      case (state)
         S_RESET: state_next = S_IDLE;
         S_IDLE:  state_next = rempty ? S_IDLE : S_POP;
         S_POP:   state_next = S_CHECK;
         S_CHECK: state_next = S_IDLE;
         default: state_next = S_RESET;
      endcase
   end

   always_ff @(posedge rclk) begin
      if (rrst) state <= S_RESET;
      else      state <= state_next;
   end

   // Moore outputs: decoded from the state register only.
   assign rinc   = (state == S_POP);
   assign rvalid = (state == S_CHECK);

   // A word with an even number of ones is a parity error.
   assign par_hit = ~(^rword);

   assign err_sum  = {1'b0, err_cnt} + (ECW+1)'(par_hit) + (ECW+1)'(seq_hit);
   assign err_next = err_sum[ECW] ? {ECW{1'b1}} : err_sum[ECW-1:0];

   always_ff @(posedge rclk) begin
      if (rrst) begin
         rword      <= '0;
         word_cnt   <= '0;
         parity_err <= 1'b0;
         err_cnt    <= '0;
      end else begin
         if (state == S_POP) rword <= rdata;
         if (state == S_CHECK) begin
            word_cnt   <= word_cnt + 16'd1;
            parity_err <= parity_err | par_hit;
            err_cnt    <= err_next;
         end
      end
   end

`ifdef READ_SEQ_CHECK_EN
   logic [DW-1:0] prev_word;
   logic          have_prev;
   logic [DW-1:0] delta;

   // Consecutive checked words must advance by 1..3 modulo 2^DW.
   assign delta   = rword - prev_word;
   assign seq_hit = have_prev && ((delta == '0) || (delta > DW'(3)));

   always_ff @(posedge rclk) begin
      if (rrst) begin
         prev_word <= '0;
         have_prev <= 1'b0;
         seq_err   <= 1'b0;
      end else if (state == S_CHECK) begin
         prev_word <= rword;
         have_prev <= 1'b1;
         seq_err   <= seq_err | seq_hit;
      end
   end
`else
   assign seq_hit = 1'b0;
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_read_module.sv
// Randomized self-checking bench for read_module against a word-level reference model.
module tb_read_module;
   localparam int DW  = 16;
   localparam int ECW = 8;
   localparam int ERR_MAX = (1 << ECW) - 1;
`ifdef READ_SEQ_CHECK_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif
   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rrst = 1'b1;
   logic           rempty = 1'b1;
   logic [DW-1:0]  rdata = '0;
   logic           rinc;
   logic [DW-1:0]  rword;
   logic           rvalid;
   logic [15:0]    word_cnt;
   logic           parity_err;
   logic           seq_err;
   logic [ECW-1:0] err_cnt;
   logic [1:0]     state;

   read_module #(.DW(DW), .ECW(ECW)) dut (
      .rclk(clk), .rrst(rrst), .rempty(rempty), .rdata(rdata),
      .rinc(rinc), .rword(rword), .rvalid(rvalid), .word_cnt(word_cnt),
      .parity_err(parity_err), .seq_err(seq_err), .err_cnt(err_cnt),
      .state(state)
   );

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_q[$];

   // reference model state
   int m_cnt, m_err, m_prev;
   bit m_par, m_seq, m_have;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_err = 0; m_prev = 0;
      m_par = 0; m_seq = 0; m_have = 0;
      exp_q.delete();
   endtask

   task automatic model_word(input int w);
      int n, d;
      n = 0;
      m_cnt = (m_cnt + 1) % 65536;
      if ($countones(w) % 2 == 0) begin
         m_par = 1; n++;
      end
      if (SEQ_EN && m_have) begin
         d = (w - m_prev + 65536) % 65536;
         if (d < 1 || d > 3) begin
            m_seq = 1; n++;
         end
      end
      m_have = 1;
      m_prev = w;
      m_err = (m_err + n > ERR_MAX) ? ERR_MAX : m_err + n;
   endtask

   // Called at a negedge; leaves the DUT in IDLE at a negedge.
   task automatic do_reset();
      rrst = 1'b1;
      rempty = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_rinc", rinc, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_flags", {parity_err, seq_err}, 0);
      check("rst_rword", rword, 0);
      rrst = 1'b0;
      @(negedge clk);
      check("rst_state_idle", state, ST_IDLE);
      model_reset();
   endtask

   // driver: present one word on the show-ahead port and follow it through the FSM
   task automatic send_word(input logic [DW-1:0] w, input int gap);
      int t;
      rempty = 1'b1;
      repeat (gap) @(negedge clk);
      rdata = w;
      rempty = 1'b0;
      exp_q.push_back(w);
      t = 0;
      @(negedge clk);
      while (!rinc && t < 8) begin
         @(negedge clk);
         t++;
      end
      if (!rinc) begin
         check("rinc_timeout", 0, 1);
         rempty = 1'b1;
         exp_q.delete();
         return;
      end
      check("pop_latency", t, 0);
      check("pop_rvalid", rvalid, 0);
      rempty = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("chk_rinc", rinc, 0);
      check("chk_rvalid", rvalid, 1);
      check("chk_rword", rword, exp_q.pop_front());
      model_word(int'(w));
      rdata = DW'($urandom);
      rempty = 1'b1;
      @(negedge clk);
      check("post_rvalid", rvalid, 0);
      check("post_rinc", rinc, 0);
      check("word_cnt", word_cnt, m_cnt);
      check("parity_err", parity_err, m_par);
      check("seq_err", seq_err, m_seq);
      check("err_cnt", err_cnt, m_err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] w, last;
      @(negedge clk);
      do_reset();

      // single clean word
      send_word(16'h0001, 0);
      check("single_cnt", word_cnt, 1);
      check("single_err", err_cnt, 0);

      // parity error, then a clean word keeps the sticky flag
      do_reset();
      send_word(16'h0003, 1);
      check("par_flag", parity_err, 1);
      check("par_errcnt", err_cnt, 1);
      send_word(16'h0004, 0);
      check("par_sticky", parity_err, 1);
      check("par_errcnt2", err_cnt, 1);

      // sequence jump of 6
      do_reset();
      send_word(16'h0001, 0);
      send_word(16'h0002, 2);
      send_word(16'h0008, 0);
      check("seq_third", seq_err, SEQ_EN);
      check("seq_errcnt", err_cnt, 32'(SEQ_EN));

      // numeric wrap of the sequence
      do_reset();
      send_word(16'h7FFF, 0);
      send_word(16'h8000, 1);
      check("wrap_seq", seq_err, 0);
      check("wrap_err", err_cnt, 0);

      // reset landing on a POP edge discards the word
      send_word(16'h8001, 0);
      rdata = 16'h8002;
      rempty = 1'b0;
      @(negedge clk);
      check("rpop_rinc", rinc, 1);
      rrst = 1'b1;
      rempty = 1'b1;
      @(negedge clk);
      check("rpop_state", state, ST_RESET);
      check("rpop_cnt", word_cnt, 0);
      check("rpop_rword", rword, 0);
      rrst = 1'b0;
      @(negedge clk);
      model_reset();
      check("rpop_idle", state, ST_IDLE);
      check("rpop_cnt2", word_cnt, 0);
      check("rpop_rvalid", rvalid, 0);

      // saturation with even-parity words
      for (int i = 0; i < 300; i++) begin
         w = DW'($urandom);
         if ($countones(w) % 2 == 1) w[0] = ~w[0];
         send_word(w, 0);
      end
      check("sat_errcnt", err_cnt, 32'hFF);
      check("sat_cnt", word_cnt, 300);

      // randomized mix of in-order and out-of-order words
      do_reset();
      last = '0;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) != 0) w = last + DW'($urandom_range(1, 3));
         else w = DW'($urandom);
         if ($urandom_range(0, 4) != 0 && $countones(w) % 2 == 0) w[DW-1] = ~w[DW-1];
         send_word(w, $urandom_range(0, 3));
         last = w;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
